// File: rtl/inst_fetch_buffer_pkg.sv
// inst_fetch_buffer_pkg: shared fetch-stage constants, state encoding and queue entry type
package inst_fetch_buffer_pkg;
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_buffer_pc_fifo.sv
// inst_pc_fifo: DEPTH x {pc,inst} synchronous FIFO with flush; push and pop may coincide when full
module inst_pc_fifo
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         valid_o,
  output logic [AW:0]  count_o
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_pop;
  assign do_pop = pop_i && (cnt_q != '0);
  assign valid_o = cnt_q != '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: IF stage owning the PC, one outstanding word fetch, queueing {pc,inst} for decode
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_req_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  if_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [CW-1:0] count;
  logic head_valid, free, accept, push, pop;
  fetch_entry_t head;
  // Slots already promised to the in-flight request count as used
  assign free = (count + CW'(state_q != IF_FETCH)) < CW'(DEPTH);
  assign im_req_valid = !rst && !redirect && state_q == IF_FETCH && free;
  assign im_req_addr = pc_q;
  assign accept = im_req_valid && im_req_ready;
  assign push = state_q == IF_WAIT && im_rsp_valid && !redirect;
  assign pop = head_valid && id_ready && !redirect;
  assign id_valid = head_valid;
  assign id_inst = head_valid ? head.inst : RV32_NOP;
  assign id_pc = head_valid ? head.pc : '0;
  inst_pc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ('{pc: req_pc_q, inst: im_rsp_data}),
    .rdata_o (head),
    .valid_o (head_valid),
    .count_o (count)
  );
  always_comb begin
    state_d = state_q;
    pc_d = accept ? pc_q + 32'd4 : pc_q;
    req_pc_d = accept ? pc_q : req_pc_q;
    if (redirect) pc_d = {redirect_pc[31:2], 2'b00};
    unique case (state_q)
      IF_FETCH: state_d = accept ? IF_WAIT : IF_FETCH;
      IF_WAIT:  state_d = im_rsp_valid ? IF_FETCH : (redirect ? IF_DROP : IF_WAIT);
      IF_DROP:  state_d = im_rsp_valid ? IF_FETCH : IF_DROP;
      default:  state_d = IF_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IF_FETCH;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed fetch scenarios with a scoreboard of expected {pc,inst} pops
module tb_inst_fetch_buffer;
  import inst_fetch_buffer_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic im_req_valid;
  logic im_req_ready = 1'b0;
  logic [31:0] im_req_addr;
  logic im_rsp_valid = 1'b0;
  logic [31:0] im_rsp_data = '0;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic id_valid;
  logic id_ready = 1'b0;
  logic [31:0] id_inst, id_pc;
  int checks = 0;
  int errors = 0;
  int lat = 1;
  int m_timer = 0;
  logic m_acc;
  logic [31:0] m_addr, m_cur;
  logic [63:0] exp_q[$];
  logic [31:0] acc_q[$];
  logic [63:0] exp_e;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .im_req_valid (im_req_valid),
    .im_req_ready (im_req_ready),
    .im_req_addr  (im_req_addr),
    .im_rsp_valid (im_rsp_valid),
    .im_rsp_data  (im_rsp_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_inst      (id_inst),
    .id_pc        (id_pc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n);
    int g;
    g = 0;
    while (acc_q.size() < n && g < 60) begin
      @(negedge clk);
      g++;
    end
    chk("accept_count", 64'(acc_q.size()), 64'(n));
  endtask

  // Memory: accepts sampled mid-cycle, word returned lat cycles after the accepting edge
  initial forever begin
    @(negedge clk);
    m_acc = im_req_valid && im_req_ready;
    m_cur = im_req_addr;
    @(posedge clk);
    #1;
    im_rsp_valid = 1'b0;
    if (m_acc) begin
      acc_q.push_back(m_cur);
      m_addr = m_cur;
      m_timer = lat;
    end
    if (m_timer > 0) begin
      m_timer--;
      if (m_timer == 0) begin
        im_rsp_valid = 1'b1;
        im_rsp_data = 32'hC0DE_0000 | m_addr;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && id_valid && id_ready && !redirect) begin
      if (exp_q.size() == 0) chk("pop_unexpected", {id_pc, id_inst}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        exp_e = exp_q.pop_front();
        chk("pop_entry", {id_pc, id_inst}, exp_e);
      end
    end
  end

  initial begin
    tick(3);
    @(negedge clk);
    chk("rst_req_valid", 64'(im_req_valid), 64'd0);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_inst", 64'(id_inst), 64'h13);
    chk("rst_id_pc", 64'(id_pc), 64'd0);
    tick(1);
    rst = 1'b0;
    id_ready = 1'b1;
    im_req_ready = 1'b1;
    lat = 1;
    exp_q.push_back(64'h0000_0000_C0DE_0000);
    exp_q.push_back(64'h0000_0004_C0DE_0004);
    exp_q.push_back(64'h0000_0008_C0DE_0008);
    wait_acc(3);
    tick(1);
    im_req_ready = 1'b0;
    tick(4);
    @(negedge clk);
    chk("s1_addr0", 64'(acc_q[0]), 64'h0);
    chk("s1_addr1", 64'(acc_q[1]), 64'h4);
    chk("s1_addr2", 64'(acc_q[2]), 64'h8);
    chk("s1_hold_valid", 64'(im_req_valid), 64'd1);
    chk("s1_hold_addr", 64'(im_req_addr), 64'hC);
    chk("s1_drained", 64'(exp_q.size()), 64'd0);
    // Decode stalled: queue fills to DEPTH and fetching stops
    tick(1);
    id_ready = 1'b0;
    im_req_ready = 1'b1;
    exp_q.push_back(64'h0000_000C_C0DE_000C);
    exp_q.push_back(64'h0000_0010_C0DE_0010);
    tick(10);
    @(negedge clk);
    chk("s2_full_no_req", 64'(im_req_valid), 64'd0);
    chk("s2_accepts", 64'(acc_q.size()), 64'd5);
    chk("s2_head_pc", 64'(id_pc), 64'hC);
    tick(1);
    im_req_ready = 1'b0;
    id_ready = 1'b1;
    tick(4);
    @(negedge clk);
    chk("s2_drained", 64'(exp_q.size()), 64'd0);
    tick(1);
    repeat (3) begin
      @(negedge clk);
      chk("s3_stall_valid", 64'(im_req_valid), 64'd1);
      chk("s3_stall_addr", 64'(im_req_addr), 64'h14);
      tick(1);
    end
    im_req_ready = 1'b1;
    exp_q.push_back(64'h0000_0014_C0DE_0014);
    tick(1);
    im_req_ready = 1'b0;
    tick(4);
    @(negedge clk);
    chk("s3_accepts", 64'(acc_q.size()), 64'd6);
    chk("s3_addr", 64'(acc_q[5]), 64'h14);
    chk("s3_pc_next", 64'(im_req_addr), 64'h18);
    chk("s3_drained", 64'(exp_q.size()), 64'd0);
    // Redirect while waiting on a slow response
    tick(1);
    lat = 3;
    im_req_ready = 1'b1;
    wait_acc(7);
    tick(1);
    im_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("s4_no_req_on_redirect", 64'(im_req_valid), 64'd0);
    tick(1);
    redirect = 1'b0;
    lat = 1;
    im_req_ready = 1'b1;
    exp_q.push_back(64'h0000_0100_C0DE_0100);
    wait_acc(8);
    tick(1);
    im_req_ready = 1'b0;
    tick(4);
    @(negedge clk);
    chk("s4_redirect_addr", 64'(acc_q[7]), 64'h100);
    chk("s4_drained", 64'(exp_q.size()), 64'd0);
    // Redirect in the same cycle as a response and a decode pop
    tick(1);
    id_ready = 1'b0;
    lat = 2;
    im_req_ready = 1'b1;
    wait_acc(10);
    tick(1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    id_ready = 1'b1;
    im_req_ready = 1'b0;
    @(negedge clk);
    chk("s5_head_before", 64'(id_pc), 64'h104);
    tick(1);
    redirect = 1'b0;
    id_ready = 1'b0;
    @(negedge clk);
    chk("s5_id_valid", 64'(id_valid), 64'd0);
    chk("s5_id_inst", 64'(id_inst), 64'h13);
    chk("s5_id_pc", 64'(id_pc), 64'd0);
    chk("s5_new_req", 64'(im_req_valid), 64'd1);
    chk("s5_new_addr", 64'(im_req_addr), 64'h200);
    // Reset during an outstanding fetch; late response must be ignored
    tick(1);
    lat = 3;
    id_ready = 1'b1;
    im_req_ready = 1'b1;
    wait_acc(11);
    tick(1);
    rst = 1'b1;
    im_req_ready = 1'b0;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("s6_late_rsp_seen", 64'(im_rsp_valid), 64'd1);
    chk("s6_req_valid", 64'(im_req_valid), 64'd1);
    chk("s6_reset_addr", 64'(im_req_addr), 64'h0);
    tick(3);
    @(negedge clk);
    chk("s6_not_queued", 64'(id_valid), 64'd0);
    tick(1);
    lat = 1;
    im_req_ready = 1'b1;
    exp_q.push_back(64'h0000_0000_C0DE_0000);
    wait_acc(12);
    tick(1);
    im_req_ready = 1'b0;
    tick(4);
    @(negedge clk);
    chk("s6_first_addr", 64'(acc_q[11]), 64'h0);
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
